// File: rtl/alu_op_issuer_if.sv
// alu_op_issuer_if: request, ALU and response signals for alu_op_issuer.
//
// Handshake semantics (request and response channels alike): a transfer
// happens on the rising clk edge where valid and ready are both high.
// The source raises valid and then holds its payload stable until that
// transfer edge. The sink may drive ready without regard to valid.
// The ALU signals are not a handshake. alu_a/alu_b/alu_cmd come from
// registers, and alu_result is the combinational ALU answer to them.
interface alu_op_issuer_if #(
  parameter int W     = 32,
  parameter int CNT_W = 8
);
  // request channel (decode stage -> issuer)
  logic             req_valid;
  logic             req_ready;
  logic [5:0]       req_opcode;
  logic [5:0]       req_funct;
  logic [W-1:0]     req_rs_val;
  logic [W-1:0]     req_rt_val;
  logic [15:0]      req_imm;

  // ALU ports (issuer <-> combinational ALU)
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [2:0]       alu_cmd;
  logic [W-1:0]     alu_result;

  // response channel (issuer -> consumer)
  logic             resp_valid;
  logic             resp_ready;
  logic [W-1:0]     resp_data;
  logic             resp_err;
  logic [CNT_W-1:0] mismatch_cnt;

  // issuer side
  modport slave (
    input  req_valid, req_opcode, req_funct, req_rs_val, req_rt_val, req_imm,
    output req_ready,
    output alu_a, alu_b, alu_cmd,
    input  alu_result,
    output resp_valid, resp_data, resp_err, mismatch_cnt,
    input  resp_ready
  );

  // environment side (decode stage, ALU and response consumer)
  modport master (
    output req_valid, req_opcode, req_funct, req_rs_val, req_rt_val, req_imm,
    input  req_ready,
    input  alu_a, alu_b, alu_cmd,
    output alu_result,
    input  resp_valid, resp_data, resp_err, mismatch_cnt,
    output resp_ready
  );
endinterface

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: takes MIPS-style operation requests and decodes them into
// ALU command and operands. It drives the combinational ALU from registers,
// captures the ALU result and returns it on a response channel.
// Optional build macro ALU_RESULT_CHECK_EN adds a golden model. The model
// flags ALU results that differ from the expected value (resp_err) and counts
// them in a saturating mismatch counter. Without the macro, mismatch_cnt
// reads 0 and resp_err reports illegal decodes only.
// o_dbg_state exposes the FSM state (0 idle, 1 exec, 2 resp).
module alu_op_issuer #(
  parameter int W     = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_op_issuer_if.slave   bus,
  output logic [1:0]       o_dbg_state
);

  // ALU command encoding
  localparam logic [2:0] CMD_ADD  = 3'd0;
  localparam logic [2:0] CMD_SUB  = 3'd1;
  localparam logic [2:0] CMD_XOR  = 3'd2;
  localparam logic [2:0] CMD_SLT  = 3'd3;
  localparam logic [2:0] CMD_AND  = 3'd4;
  localparam logic [2:0] CMD_NOR  = 3'd6;
  localparam logic [2:0] CMD_OR   = 3'd7;

  // MIPS opcodes that are understood
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic           w_req_ready;
  logic           w_resp_valid;
  logic           w_accept;
  logic           w_capture;

  // decoded request (combinational, only registered on accept)
  logic [2:0]     w_cmd;
  logic [W-1:0]   w_b;
  logic           w_illegal;
  logic [W-1:0]   w_imm_sext;
  logic [W-1:0]   w_imm_zext;

  // operation held for the ALU and the captured response
  logic [W-1:0]   r_alu_a;
  logic [W-1:0]   r_alu_b;
  logic [2:0]     r_alu_cmd;
  logic           r_illegal;
  logic [W-1:0]   r_resp_data;
  logic           r_resp_err;

  // true when the ALU answer disagrees with the golden model
  logic           w_mismatch;

  // immediate extensions used by the I-type decode
  assign w_imm_sext = {{(W-16){bus.req_imm[15]}}, bus.req_imm};
  assign w_imm_zext = {{(W-16){1'b0}}, bus.req_imm};

  // decode opcode/funct into ALU command, operand b and the illegal flag;
  // operand a is always rs, and unknown encodings fall back to ADD rs,rt
  always_comb begin
    w_cmd     = CMD_ADD;
    w_b       = bus.req_rt_val;
    w_illegal = 1'b0;
    case (bus.req_opcode)
      OP_RTYPE: begin
        case (bus.req_funct)
          FN_ADD, FN_ADDU: w_cmd = CMD_ADD;
          FN_SUB, FN_SUBU: w_cmd = CMD_SUB;
          FN_AND:          w_cmd = CMD_AND;
          FN_OR:           w_cmd = CMD_OR;
          FN_XOR:          w_cmd = CMD_XOR;
          FN_NOR:          w_cmd = CMD_NOR;
          FN_SLT:          w_cmd = CMD_SLT;
          default:         w_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        w_cmd = CMD_ADD;
        w_b   = w_imm_sext;
      end
      OP_SLTI: begin
        w_cmd = CMD_SLT;
        w_b   = w_imm_sext;
      end
      OP_ANDI: begin
        w_cmd = CMD_AND;
        w_b   = w_imm_zext;
      end
      OP_ORI: begin
        w_cmd = CMD_OR;
        w_b   = w_imm_zext;
      end
      OP_XORI: begin
        w_cmd = CMD_XOR;
        w_b   = w_imm_zext;
      end
      OP_BEQ: begin
        w_cmd = CMD_SUB;
        w_b   = bus.req_rt_val;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state and handshake/strobe outputs
  always_comb begin
    w_next_state = r_state;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          w_accept     = 1'b1;
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        // ALU has had a full cycle on the registered operands
        w_capture    = 1'b1;
        w_next_state = S_RESP;
      end
      S_RESP: begin
        w_resp_valid = 1'b1;
        if (bus.resp_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // register the decoded operation on accept and capture the result on leaving EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_cmd   <= CMD_ADD;
      r_illegal   <= 1'b0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_a   <= bus.req_rs_val;
        r_alu_b   <= w_b;
        r_alu_cmd <= w_cmd;
        r_illegal <= w_illegal;
      end
      if (w_capture) begin
        r_resp_data <= bus.alu_result;
        r_resp_err  <= r_illegal | w_mismatch;
      end
    end
  end

`ifdef ALU_RESULT_CHECK_EN
  localparam logic [2:0]       CMD_NAND = 3'd5;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [W-1:0]     w_expected;
  logic [CNT_W-1:0] r_mismatch_cnt;

  // golden model of the ALU evaluated on the registered command/operands
  always_comb begin
    w_expected = '0;
    case (r_alu_cmd)
      CMD_ADD:  w_expected = r_alu_a + r_alu_b;
      CMD_SUB:  w_expected = r_alu_a - r_alu_b;
      CMD_XOR:  w_expected = r_alu_a ^ r_alu_b;
      CMD_SLT:  w_expected = {{(W-1){1'b0}}, ($signed(r_alu_a) < $signed(r_alu_b))};
      CMD_AND:  w_expected = r_alu_a & r_alu_b;
      CMD_NAND: w_expected = ~(r_alu_a & r_alu_b);
      CMD_NOR:  w_expected = ~(r_alu_a | r_alu_b);
      CMD_OR:   w_expected = r_alu_a | r_alu_b;
      default:  w_expected = '0;
    endcase
  end

  assign w_mismatch = (bus.alu_result != w_expected);

  // saturating count of captures where the ALU disagreed with the model
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mismatch_cnt <= '0;
    end else if (w_capture && w_mismatch && (r_mismatch_cnt != CNT_MAX)) begin
      r_mismatch_cnt <= r_mismatch_cnt + CNT_ONE;
    end
  end

  assign bus.mismatch_cnt = r_mismatch_cnt;
`else
  assign w_mismatch       = 1'b0;
  assign bus.mismatch_cnt = {CNT_W{1'b0}};
`endif

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_err   = r_resp_err;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_cmd    = r_alu_cmd;
  assign o_dbg_state    = r_state;

endmodule
